// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU-op encodings and types for the shared-ALU arbiter slice.
package alu_share_arbiter_pkg;

    localparam int unsigned ALUSEL_W = 15;
    localparam int unsigned DATA_W   = 32;

    typedef logic [ALUSEL_W-1:0] alusel_t;
    typedef logic [DATA_W-1:0]   word_t;

    localparam alusel_t ALU_ADD  = 15'h0001;
    localparam alusel_t ALU_SUB  = 15'h0002;
    localparam alusel_t ALU_SLL  = 15'h0004;
    localparam alusel_t ALU_SLT  = 15'h0008;
    localparam alusel_t ALU_SLTU = 15'h0010;
    localparam alusel_t ALU_XOR  = 15'h0020;
    localparam alusel_t ALU_SRL  = 15'h0040;
    localparam alusel_t ALU_SRA  = 15'h0080;
    localparam alusel_t ALU_OR   = 15'h0100;
    localparam alusel_t ALU_AND  = 15'h0200;

    // Width of a requester index: max(1, clog2(n)).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesting stages and the shared ALU.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
);
    import alu_share_arbiter_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*32-1:0]       req_src1;
    logic [NUM_REQ*32-1:0]       req_src2;
    logic [NUM_REQ*ALUSEL_W-1:0] req_alusel;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [31:0]                 resp_data;

    modport master (
        output req_valid, req_src1, req_src2, req_alusel, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_src1, req_src2, req_alusel, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational integer ALU; unrecognised selects produce zero.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  word_t   src1_i,
    input  word_t   src2_i,
    input  alusel_t alusel_i,
    output word_t   result_o
);

    logic [4:0] shamt;

    assign shamt = src2_i[4:0];

    always_comb begin
        result_o = '0;
        case (alusel_i)
            ALU_ADD:  result_o = src1_i + src2_i;
            ALU_SUB:  result_o = src1_i - src2_i;
            ALU_SLL:  result_o = src1_i << shamt;
            ALU_SLT:  result_o = {31'b0, $signed(src1_i) < $signed(src2_i)};
            ALU_SLTU: result_o = {31'b0, src1_i < src2_i};
            ALU_XOR:  result_o = src1_i ^ src2_i;
            ALU_SRL:  result_o = src1_i >> shamt;
            ALU_SRA:  result_o = word_t'($signed(src1_i) >>> shamt);
            ALU_OR:   result_o = src1_i | src2_i;
            ALU_AND:  result_o = src1_i & src2_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters,
// with a single registered result slot and requester-ID tagging.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave arb
);

    logic [ID_W-1:0] prio_ptr_q;
    logic [ID_W-1:0] prio_ptr_d;
    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    word_t           resp_data_q;

    logic            slot_free;
    logic [ID_W:0]   pick;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;

    word_t           mux_src1;
    word_t           mux_src2;
    alusel_t         mux_sel;
    word_t           alu_result;

    // Returns {found, index} of the first valid requester at or after ptr.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] sel;
        int unsigned   j;
        sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr) + k) % NUM_REQ;
            if (!sel[ID_W] && valid[j]) begin
                sel = {1'b1, j[ID_W-1:0]};
            end
        end
        return sel;
    endfunction

    // Grant path is built only from valids, the pointer and slot state,
    // so req_ready never depends on the ALU result.
    assign slot_free = !resp_valid_q || arb.resp_ready;
    assign pick      = rr_pick(arb.req_valid, prio_ptr_q);
    assign grant_vld = !rst && slot_free && pick[ID_W];
    assign grant_idx = pick[ID_W-1:0];

    always_comb begin
        arb.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            arb.req_ready[i] = grant_vld && (grant_idx == ID_W'(i));
        end
    end

    always_comb begin
        mux_src1 = '0;
        mux_src2 = '0;
        mux_sel  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                mux_src1 = arb.req_src1[32*i +: 32];
                mux_src2 = arb.req_src2[32*i +: 32];
                mux_sel  = arb.req_alusel[ALUSEL_W*i +: ALUSEL_W];
            end
        end
    end

    alu_share_arbiter_alu u_alu (
        .src1_i   (mux_src1),
        .src2_i   (mux_src2),
        .alusel_i (mux_sel),
        .result_o (alu_result)
    );

    assign prio_ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else if (grant_vld) begin
            prio_ptr_q   <= prio_ptr_d;
            resp_valid_q <= 1'b1;
            resp_id_q    <= grant_idx;
            resp_data_q  <= alu_result;
        end else if (arb.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign arb.resp_valid = resp_valid_q;
    assign arb.resp_id    = resp_id_q;
    assign arb.resp_data  = resp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with four requesters.
module tb_alu_share_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) arb ();

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    typedef struct {
        int unsigned id;
        logic [31:0] data;
    } exp_t;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    int unsigned rec_q[$];
    bit          rec_en = 1'b0;
    bit          mvalid = 1'b0;
    int unsigned mptr   = 0;
    logic [N-1:0] last_ready = '0;

    logic [14:0] ops[10] = '{15'h0001, 15'h0002, 15'h0004, 15'h0008, 15'h0010,
                             15'h0020, 15'h0040, 15'h0080, 15'h0100, 15'h0200};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU expressed directly from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [14:0] s);
        int unsigned sh;
        sh = b % 32;
        case (s)
            15'h0001: return a + b;
            15'h0002: return a + ~b + 32'd1;
            15'h0004: return a << sh;
            15'h0008: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            15'h0010: return (a < b) ? 32'd1 : 32'd0;
            15'h0020: return a ^ b;
            15'h0040: return a >> sh;
            15'h0080: return a[31] ? ~((~a) >> sh) : (a >> sh);
            15'h0100: return a | b;
            15'h0200: return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic set_req(input int unsigned i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [14:0] s);
        arb.req_valid[i]            = v;
        arb.req_src1[32*i +: 32]    = a;
        arb.req_src2[32*i +: 32]    = b;
        arb.req_alusel[15*i +: 15]  = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: decides the grant from the round-robin rule and
    // queues the expected response for the monitor.
    always @(negedge clk) begin : model
        int g;
        int unsigned idx;
        logic [N-1:0] exp_ready;
        logic [N*32-1:0] s1, s2;
        logic [N*15-1:0] sl;
        last_ready = arb.req_ready;
        if (rst) begin
            chk("req_ready_in_reset", 32'(arb.req_ready), 32'd0);
            mvalid = 1'b0;
            mptr   = 0;
            exp_q.delete();
        end else begin
            chk("resp_valid", 32'(arb.resp_valid), 32'(mvalid));
            g = -1;
            if (!mvalid || arb.resp_ready) begin
                for (int k = 0; k < int'(N); k++) begin
                    idx = (mptr + k) % N;
                    if (g < 0 && arb.req_valid[idx]) g = int'(idx);
                end
            end
            exp_ready = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", 32'(arb.req_ready), 32'(exp_ready));
            if (g >= 0) begin
                s1 = arb.req_src1;
                s2 = arb.req_src2;
                sl = arb.req_alusel;
                exp_q.push_back('{id: g, data: ref_alu(s1[32*g +: 32], s2[32*g +: 32], sl[15*g +: 15])});
                mptr   = (g + 1) % N;
                mvalid = 1'b1;
                if (rec_en) rec_q.push_back(g);
            end else if (arb.resp_ready) begin
                mvalid = 1'b0;
            end
        end
    end

    bit          hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] prev_id;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(arb.resp_valid), 32'd1);
                chk("hold_data", arb.resp_data, prev_data);
                chk("hold_id", 32'(arb.resp_id), prev_id);
            end
            if (arb.resp_valid && arb.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", 32'(arb.resp_id), 32'(e.id));
                    chk("resp_data", arb.resp_data, e.data);
                end
            end
        end
        hold_prev = !rst && arb.resp_valid && !arb.resp_ready;
        prev_data = arb.resp_data;
        prev_id   = 32'(arb.resp_id);
    end

    task automatic idle_all();
        for (int unsigned i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_now(input string name, input int unsigned id, input logic [31:0] data);
        @(negedge clk);
        chk({name, "_valid"}, 32'(arb.resp_valid), 32'd1);
        chk({name, "_id"}, 32'(arb.resp_id), 32'(id));
        chk({name, "_data"}, arb.resp_data, data);
    endtask

    initial begin
        int unsigned cnt[N];
        arb.resp_ready = 1'b0;
        idle_all();

        // Reset then idle
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(arb.resp_valid), 32'd0);
        chk("rst_id", 32'(arb.resp_id), 32'd0);
        chk("rst_data", arb.resp_data, 32'd0);
        chk("rst_ready", 32'(arb.req_ready), 32'd0);

        // Single op: wrapping ADD
        arb.resp_ready = 1'b1;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd2, 15'h0001);
        tick();
        idle_all();
        expect_now("single", 0, 32'h0000_0001);
        tick();

        // Contention between requesters 0 and 1
        do_reset();
        arb.resp_ready = 1'b1;
        set_req(0, 1'b1, 32'd5, 32'd7, 15'h0002);
        set_req(1, 1'b1, 32'h8000_0000, 32'h24, 15'h0080);
        rec_en = 1'b1;
        repeat (4) tick();
        rec_en = 1'b0;
        idle_all();
        chk("cont_count", rec_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < rec_q.size(); k++) chk("cont_order", rec_q[k], 32'(k % 2));
        rec_q.delete();
        tick();

        // Back-pressure
        arb.resp_ready = 1'b0;
        set_req(0, 1'b1, 32'd10, 32'd20, 15'h0001);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_003C, 15'h0200);
        repeat (3) tick();
        arb.resp_ready = 1'b1;
        tick();
        idle_all();
        expect_now("bp", 1, 32'h0000_0030);
        tick();

        // Signed vs unsigned compare, unknown select
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 15'h0008);
        tick();
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 15'h0010);
        expect_now("slt", 1, 32'd1);
        tick();
        set_req(1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 15'h0000);
        expect_now("sltu", 1, 32'd0);
        tick();
        idle_all();
        expect_now("unknown", 1, 32'd0);
        tick();

        // Reset in the cycle after an accept drops the held result
        arb.resp_ready = 1'b0;
        set_req(0, 1'b1, 32'd1, 32'd1, 15'h0001);
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(arb.resp_valid), 32'd0);

        // Fairness sweep with idle gap
        arb.resp_ready = 1'b1;
        for (int unsigned i = 0; i < N; i++) set_req(i, 1'b1, 32'(100 + i), 32'(3 * i + 1), ops[i]);
        rec_en = 1'b1;
        tick();
        repeat (5) tick();
        idle_all();
        repeat (3) tick();
        for (int unsigned i = 0; i < N; i++) set_req(i, 1'b1, 32'(200 + i), 32'(i + 2), ops[i + 4]);
        repeat (6) tick();
        rec_en = 1'b0;
        idle_all();
        chk("fair_count", rec_q.size(), 32'd12);
        for (int unsigned i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < rec_q.size(); k++) begin
            chk("fair_order", rec_q[k], 32'(k % 4));
            if (rec_q[k] < N) cnt[rec_q[k]]++;
        end
        for (int unsigned i = 0; i < N; i++) chk("fair_per_id", cnt[i], 32'd3);
        rec_q.delete();
        tick();

        // Randomized traffic honouring the operand-stability obligation
        for (int c = 0; c < 400; c++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!(arb.req_valid[i] && !last_ready[i])) begin
                    set_req(i, ($urandom_range(0, 2) != 0),
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                            ($urandom_range(0, 9) == 0) ? 15'($urandom) : ops[$urandom_range(0, 9)]);
                end
            end
            arb.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle_all();
        arb.resp_ready = 1'b1;
        repeat (3) tick();
        chk("drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the execute stage and the address-generation/CSR path.
- Round-robin arbitration with valid/ready request handshakes.
- Single registered result slot with a valid/ready response handshake and a requester ID.
- Sits between the requesting stages and the ALU; fixed 1-cycle issue-to-result latency when the response side is not back-pressured.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- ID_W, 1: width of resp_id; must equal max(1, clog2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  bit i: requester i presents an operation.
- req_ready  output  NUM_REQ  bit i: requester i's operation is accepted this cycle.
- req_src1  input  NUM_REQ*32  operand 1; slice i is [32*i+31:32*i].
- req_src2  input  NUM_REQ*32  operand 2, same slicing.
- req_alusel  input  NUM_REQ*15  ALU select; slice i is [15*i+14:15*i]; encodings are the shared ALU-op constants.
- resp_valid  output  1  result slot holds a result.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  ID_W  index of the requester that owns resp_data.
- resp_data  output  32  ALU result.

Behaviour:
- Reset: resp_valid=0, resp_id=0, resp_data=0, prio_ptr=0, req_ready=0. Reset mid-operation discards any held result with no response.
- slot_free = !resp_valid | resp_ready.
- Grant (combinational):
  - When slot_free, grant the first requester with req_valid=1, searching from prio_ptr upward with wrap modulo NUM_REQ.
  - req_ready is one-hot on the granted index; all zeros if nothing is valid or !slot_free.
  - req_ready must not depend on resp_data.
- Accept (edge where a grant exists):
  - resp_data <= ALU(src1,src2,alusel) of the granted requester.
  - resp_id <= granted index; resp_valid <= 1.
  - prio_ptr <= (granted index + 1) mod NUM_REQ.
- Drain: resp_valid & resp_ready with no new grant -> resp_valid <= 0. resp_id and resp_data hold their last values.
- Simultaneous drain + accept: allowed in the same cycle; resp_valid stays 1 and the slot takes the new result. Back-to-back throughput is 1 op/cycle.
- Hold: while resp_valid & !resp_ready, resp_data and resp_id stay stable and all req_ready=0.
- prio_ptr changes only on a grant. Idle cycles leave it unchanged.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ grants.
- Requester obligation: operands and alusel stay stable while req_valid=1 and req_ready=0. The block does not check this.
- ALU semantics:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use src2[4:0] only.
  - SLT is signed; SLTU is unsigned.
  - Any unrecognised alusel value yields 0 and still completes normally.

Decomposition:
- Shared define file:
  - The 15-bit ALU-op constants (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
  - ALUSEL_W=15.
- One sub-module: the existing ALU, instantiated once and fed by a mux on the grant index.
- Round-robin pick may be a local function. It is not a separate module.

Test Plan:
- Reset then idle:
  - After rst is held 2 cycles, resp_valid=0, resp_id=0, resp_data=0 and req_ready=0.
  - Asserting rst in the cycle after an accept clears resp_valid on the next edge.
- Single op: req0 ADD, src1=0xFFFFFFFF, src2=2, resp_ready=1 -> req_ready=01 in cycle 0; cycle 1 gives resp_valid=1, resp_id=0, resp_data=0x00000001.
- Contention:
  - Both requesters valid every cycle: req0 SUB 5-7, req1 SRA 0x80000000 by 0x24.
  - Grants alternate 0,1,0,1.
  - Results are 0xFFFFFFFE (id 0) and 0xF8000000 (id 1, shift=4).
- Back-pressure:
  - resp_ready=0 for 3 cycles with req1 valid: resp_data/resp_id held and req_ready=00.
  - When resp_ready=1, drain and req1 grant occur in the same cycle; the next cycle shows id 1's result.
- Signed vs unsigned: req1 SLT 0xFFFFFFFF,1 -> 1; SLTU with the same operands -> 0; unknown alusel 0 -> resp_data=0 with resp_valid=1.
- Fairness sweep with NUM_REQ=4:
  - All four requesters valid for 12 grants.
  - Each id is granted exactly 3 times in order 0,1,2,3 repeating.
  - Idle gaps leave the order unchanged.
